// File: rtl/core_pkg.sv
// Shared core-side constants and the fetch-to-decode entry type.
// Used by ins_fetch_q (optional feature: IFQ_BYPASS_EN) and by decode.
package core_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/clear and occupancy outputs.
// The head word is readable combinationally whenever the FIFO is not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty && !clear;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop) && !clear;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ins_fetch_q.sv
// Instruction fetch unit with prefetch queue, branch redirect and stale-response squashing.
// Define IFQ_BYPASS_EN to let a response reach ins_out in its arrival cycle when the queue is empty.
module ins_fetch_q
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            stall,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_addr,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     ins_out,
    output logic            ins_valid,
    output logic            exIns_ren,
    output logic [XLEN-1:0] exIns_addr,
    input  logic            exIns_valid,
    input  logic [31:0]     exIns_in
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] deliver_pc_q, deliver_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   kill_q, kill_d;

    logic [31:0]     fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full, fifo_push, fifo_pop;

    logic [XLEN-1:0] br_target;
    logic            credit_ok, issue, resp_accept, bypass, consume;
    fetch_entry_t    out_e;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .nrst  (nrst),
        .clear (br_en),
        .push  (fifo_push),
        .wdata (exIns_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign br_target   = br_addr & ~XLEN'(3);
    // Queued plus in-flight (non-killed) entries never exceed DEPTH, so every response has a slot.
    assign credit_ok   = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_X;
    assign issue       = nrst && !br_en && credit_ok && !fifo_full;
    assign resp_accept = exIns_valid && (kill_q == '0) && !br_en;

`ifdef IFQ_BYPASS_EN
    assign bypass = fifo_empty && resp_accept;
`else
    assign bypass = 1'b0;
`endif

    assign out_e.valid = !fifo_empty || bypass;
    assign out_e.ins   = !out_e.valid ? NOP_INST : (fifo_empty ? exIns_in : fifo_rdata);
    assign consume     = out_e.valid && !stall && !br_en;
    assign fifo_push   = resp_accept && !(bypass && !stall);
    assign fifo_pop    = !fifo_empty && !stall && !br_en;

    assign ins_valid   = out_e.valid;
    assign ins_out     = out_e.ins;
    assign pc          = deliver_pc_q;
    assign exIns_ren   = issue;
    assign exIns_addr  = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        deliver_pc_d  = deliver_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        if (br_en) begin
            fetch_pc_d    = br_target;
            deliver_pc_d  = br_target;
            // Every request still in flight must be squashed; one arriving now is dropped
            // immediately, whether it was already a killed one or a live one.
            kill_d        = kill_q + outstanding_q - CW'(exIns_valid);
            outstanding_d = '0;
        end else begin
            if (issue)   fetch_pc_d   = fetch_pc_q + XLEN'(4);
            if (consume) deliver_pc_d = deliver_pc_q + XLEN'(4);
            if (exIns_valid && kill_q != '0) kill_d = kill_q - CW'(1);
            outstanding_d = outstanding_q + CW'(issue) - CW'(resp_accept);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_pc_q    <= RESET_PC;
            deliver_pc_q  <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            deliver_pc_q  <= deliver_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

endmodule

// File: tb/tb_ins_fetch_q.sv
// Directed self-checking bench for ins_fetch_q with a variable-latency in-order memory model.
// Expectations adapt to IFQ_BYPASS_EN where the delivery timing differs.
module tb_ins_fetch_q;

`ifdef IFQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    localparam int          OFF = BYP ? 1 : 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, nrst, stall, br_en;
    logic [31:0] br_addr, pc, ins_out, exIns_addr, exIns_in;
    logic        ins_valid, exIns_ren, exIns_valid;

    int checks   = 0;
    int failures = 0;
    int lat_v    = 1;
    int n_req;

    logic [3:0]  v_pipe;
    logic [31:0] a_pipe [4];

    ins_fetch_q #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .stall       (stall),
        .br_en       (br_en),
        .br_addr     (br_addr),
        .pc          (pc),
        .ins_out     (ins_out),
        .ins_valid   (ins_valid),
        .exIns_ren   (exIns_ren),
        .exIns_addr  (exIns_addr),
        .exIns_valid (exIns_valid),
        .exIns_in    (exIns_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // In-order memory: a request in cycle c answers in cycle c+lat_v.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v_pipe <= '0;
            for (int k = 0; k < 4; k++) a_pipe[k] <= '0;
        end else begin
            v_pipe <= {v_pipe[2:0], exIns_ren};
            a_pipe[0] <= exIns_addr;
            for (int k = 1; k < 4; k++) a_pipe[k] <= a_pipe[k-1];
        end
    end
    assign exIns_valid = v_pipe[lat_v-1];
    assign exIns_in    = mem_data(a_pipe[lat_v-1]);

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int lat, input logic st);
        nrst  = 1'b0;
        br_en = 1'b0;
        repeat (2) step();
        lat_v = lat;
        stall = st;
        @(negedge clk);
        nrst = 1'b1;
        #1;
    endtask

    // Wait for the next consumed instruction and check its pc and word.
    task automatic expect_deliver(input logic [31:0] exp_pc);
        int n = 0;
        while (!(ins_valid && !stall && !br_en) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            chk("deliver_timeout", {31'b0, ins_valid}, 32'h1);
        end else begin
            chk("deliver_pc", pc, exp_pc);
            chk("deliver_ins", ins_out, mem_data(exp_pc));
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; stall = 1'b0; br_en = 1'b0; br_addr = '0;
        repeat (3) step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ins", ins_out, NOP);
        chk("rst_valid", {31'b0, ins_valid}, 32'h0);
        chk("rst_ren", {31'b0, exIns_ren}, 32'h0);
        chk("rst_addr", exIns_addr, 32'h0);

        // Sequential fetch, 1-cycle memory, no stall
        @(negedge clk); nrst = 1'b1; #1;
        chk("t1_ren_c0", {31'b0, exIns_ren}, 32'h1);
        chk("t1_addr_c0", exIns_addr, 32'h0);
        chk("t1_valid_c0", {31'b0, ins_valid}, 32'h0);
        step();
        chk("t1_addr_c1", exIns_addr, 32'h4);
        chk("t1_valid_c1", {31'b0, ins_valid}, {31'b0, BYP});
        step();
        chk("t1_addr_c2", exIns_addr, 32'h8);
        for (int k = 0; k < 6; k++) begin
            chk("t1_valid", {31'b0, ins_valid}, 32'h1);
            chk("t1_pc", pc, 32'(4 * (2 + k - OFF)));
            chk("t1_ins", ins_out, mem_data(32'(4 * (2 + k - OFF))));
            step();
        end

        // Stall for 10 cycles: exactly DEPTH requests, then ordered delivery
        do_reset(1, 1'b1);
        n_req = 0;
        for (int k = 0; k < 10; k++) begin
            if (exIns_ren) n_req++;
            step();
        end
        chk("t2_req_count", 32'(n_req), 32'd4);
        chk("t2_ren_low", {31'b0, exIns_ren}, 32'h0);
        chk("t2_valid", {31'b0, ins_valid}, 32'h1);
        chk("t2_pc_held", pc, 32'h0);
        stall = 1'b0; #1;
        for (int k = 0; k < 5; k++) expect_deliver(32'(4 * k));

        // 3-cycle memory, redirect with two requests in flight; target low bits ignored
        do_reset(3, 1'b0);
        step(); step();
        br_addr = 32'h0000_0102; br_en = 1'b1; #1;
        chk("t3_ren_br", {31'b0, exIns_ren}, 32'h0);
        step();
        br_en = 1'b0; #1;
        chk("t3_ren_after", {31'b0, exIns_ren}, 32'h1);
        chk("t3_addr_after", exIns_addr, 32'h100);
        expect_deliver(32'h100);
        expect_deliver(32'h104);
        expect_deliver(32'h108);

        // Redirect coincident with a response: it is dropped, kill = remaining in flight
        do_reset(3, 1'b0);
        step(); step(); step();
        br_addr = 32'h40; br_en = 1'b1; #1;
        step();
        br_en = 1'b0; #1;
        chk("t4_kill", {29'b0, dut.kill_q}, 32'd2);
        expect_deliver(32'h40);
        expect_deliver(32'h44);
        expect_deliver(32'h48);

        // Back-to-back redirects: last one wins
        br_addr = 32'h200; br_en = 1'b1; #1;
        step();
        br_addr = 32'h300; #1;
        chk("t5_ren_br2", {31'b0, exIns_ren}, 32'h0);
        step();
        br_en = 1'b0; #1;
        chk("t5_addr_after", exIns_addr, 32'h300);
        expect_deliver(32'h300);
        expect_deliver(32'h304);
        expect_deliver(32'h308);

        // Address wrap at the top of the space
        do_reset(1, 1'b0);
        br_addr = 32'hFFFF_FFF8; br_en = 1'b1; #1;
        step();
        br_en = 1'b0; #1;
        chk("t6_addr_r1", exIns_addr, 32'hFFFF_FFF8);
        step();
        stall = 1'b1; #1;
        chk("t6_addr_r2", exIns_addr, 32'hFFFF_FFFC);
        chk("t6_valid_resp_cycle", {31'b0, ins_valid}, {31'b0, BYP});
        chk("t6_pc_resp_cycle", pc, 32'hFFFF_FFF8);
        chk("t6_ins_resp_cycle", ins_out, BYP ? mem_data(32'hFFFF_FFF8) : NOP);
        step();
        chk("t6_addr_wrap", exIns_addr, 32'h0);
        stall = 1'b0; #1;
        expect_deliver(32'hFFFF_FFF8);
        expect_deliver(32'hFFFF_FFFC);
        expect_deliver(32'h0);
        expect_deliver(32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
